// File: rtl/signed_addsub_pipe.sv
// Two-stage pipelined signed add/subtract unit with valid/ready handshake,
// stage-2 accumulator, optional saturation and a sticky overflow flag.
module signed_addsub_pipe #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             acc_clr,
    input  logic             sticky_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             sticky_ovf
);

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [WIDTH-1:0] acc;

    logic             advance;
    logic             accept;
    logic             enter;
    logic [WIDTH-1:0] acc_opnd;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] opnd_b_eff;
    logic             sub;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] result;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    assign advance  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | advance;
    assign accept   = in_valid & in_ready;
    assign enter    = s1_valid & advance;

    // A same-edge acc_clr makes an entering accumulate op see zero as its operand.
    always_comb begin
        acc_opnd   = acc_clr ? '0 : acc;
        opnd_a     = s1_op[1] ? acc_opnd : s1_x;
        opnd_b     = s1_op[1] ? s1_x : s1_y;
        sub        = s1_op[0];
        opnd_b_eff = opnd_b ^ {WIDTH{sub}};
        sum        = {1'b0, opnd_a} + {1'b0, opnd_b_eff} + {{WIDTH{1'b0}}, sub};
        ovf        = (opnd_a[WIDTH-1] == opnd_b_eff[WIDTH-1]) &
                     (sum[WIDTH-1] != opnd_a[WIDTH-1]);
        result     = sum[WIDTH-1:0];
        if (SAT && ovf) begin
            result = opnd_a[WIDTH-1] ? MIN_VAL : MAX_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_x     <= x;
            s1_y     <= y;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s        <= result;
                negative <= result[WIDTH-1];
                zero     <= (result == '0);
                cout     <= sum[WIDTH];
                overflow <= ovf;
            end
        end
    end

    // The entering accumulate op's result takes priority over acc_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (enter && s1_op[1]) begin
            acc <= result;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (enter && ovf) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule
